seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: areset_n  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have ports: in_valid  in  1  frame request.
REQ-004 SHALL have ports: in_ready  out  1  frame can be accepted.
REQ-005 SHALL have ports: in_data  in  8  pattern bits.
REQ-006 SHALL have ports: in_len  in  3  pattern length minus 1 (1..8 bits).
REQ-007 SHALL have ports: in_rep  in  4  repetitions minus 1 (1..16).
REQ-008 SHALL have ports: abort  in  1  synchronous cancel of the current frame.
REQ-009 SHALL have ports: out  out  1  serial bit stream, registered, idle level 0.
REQ-010 SHALL have ports: busy  out  1  frame in progress.
REQ-011 SHALL have ports: done  out  1  one-cycle pulse at normal frame completion.
REQ-012 SHALL have ports: expect_hit  out  1  predicted "1-0-1" detector output for the emitted stream.

Function
REQ-013 SHALL have a control FSM with states IDLE and SHIFT.
REQ-014 SHALL drive in_ready = 1 exactly when the state is IDLE; a frame is accepted on a clk edge where in_valid && in_ready && !abort.
REQ-015 SHALL latch in_data, in_len and in_rep at acceptance; input changes after acceptance SHALL have no effect on the frame.
REQ-016 SHALL present the first bit on out in the cycle after acceptance (latency 1).
REQ-017 SHALL send bits in_data[in_len] down to in_data[0] (MSB first), one bit per cycle, ignoring bits above in_len.
REQ-018 SHALL repeat the pattern in_rep+1 times back-to-back with no gap; total frame length is (in_len+1)*(in_rep+1) cycles, maximum 128.
REQ-019 SHALL, in SHIFT, hold busy = 1 and out = the current bit.
REQ-020 SHALL, after the last bit of the last repetition, return to IDLE with out = 0, busy = 0 and done = 1 for exactly that one cycle.
REQ-021 SHALL allow a new frame to be accepted in the done cycle, giving a minimum gap of one idle 0 bit between frames.
REQ-022 SHALL, when abort = 1 in SHIFT, enter IDLE on the next edge with out = 0 and busy = 0, and SHALL NOT pulse done.
REQ-023 SHALL give abort priority over in_valid in IDLE (no acceptance in that cycle).
REQ-024 SHALL ignore in_valid while busy; no frame is queued.
REQ-025 SHALL compute expect_hit with a registered 4-state Moore model (A, B, C, D) fed by out every cycle, including idle zeros.
REQ-026 SHALL use these model transitions: A: 1->B, 0->A; B: 1->B, 0->C; C: 1->D, 0->A; D: 1->B, 0->C.
REQ-027 SHALL assert expect_hit exactly when the model state is D, i.e. one cycle after out carried the 1 that completes 1-0-1; overlapping patterns are counted.
REQ-028 SHALL NOT reset the model on abort or at frame boundaries.

Reset
REQ-029 SHALL, while areset_n = 0, immediately force: state IDLE, model state A, out = 0, busy = 0, done = 0, expect_hit = 0, in_ready = 1.
REQ-030 SHALL discard any frame in progress when reset is asserted mid-frame; after release the block idles until a new request.

Structure
REQ-031 SHALL define in a shared package: the tx state enum (IDLE, SHIFT), the model state enum (A, B, C, D), and constants for the data width (8), length width (3) and repeat width (4).
REQ-032 SHALL implement the 1-0-1 model as the sub-module seq101_model (clk, areset_n, in, hit).
REQ-033 SHALL implement the bit index and repetition counter as plain down-counters within seq_pattern_tx.

Verification
REQ-034 Bench SHALL cover: after reset, accept in_data=0x05, in_len=2, in_rep=0 at edge t -> out=1,0,1 in cycles t+1..t+3, 0 after; expect_hit=1 only at t+4; done=1 only at t+4.
REQ-035 Bench SHALL cover: in_data=0x05, in_len=2, in_rep=2 -> out=101101101; expect_hit at t+4, t+7, t+10; done at t+10; busy high t+1..t+9.
REQ-036 Bench SHALL cover overlap: in_data=0x15, in_len=4, in_rep=0 -> out=10101; expect_hit at t+4 and t+6; done at t+6.
REQ-037 Bench SHALL cover backpressure: in_valid held during a frame -> in_ready=0 and no acceptance until the done cycle; the new frame's first bit appears the cycle after done.
REQ-038 Bench SHALL cover abort in the 2nd bit of a 0xFF, in_len=7 frame -> out=0 and busy=0 on the next cycle; done never pulses; in_ready=1.
REQ-039 Bench SHALL cover reset: areset_n low mid-frame between edges -> out, busy, done and expect_hit go to 0 without a clock edge; in_ready=1.

Source files
------------

// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and widths for the serial pattern transmitter.
package seq_pattern_tx_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 3;
    localparam int REP_W  = 4;

    // Transmitter control states
    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

    // 1-0-1 prediction model states: A = nothing, B = saw 1, C = saw 1-0, D = saw 1-0-1
    typedef enum logic [1:0] {
        A,
        B,
        C,
        D
    } model_state_t;

    // Pattern captured at frame acceptance
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } pattern_t;

endpackage

// File: rtl/seq101_model.sv
// Registered Moore model predicting a "1-0-1" detector on a serial stream.
module seq101_model
    import seq_pattern_tx_pkg::*;
(
    input  logic clk,
    input  logic areset_n,
    input  logic in,
    output logic hit
);

    model_state_t st, st_d;

    // State register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) st <= A;
        else           st <= st_d;
    end

    // Next state; overlapping matches fall back to B/C rather than A
    always_comb begin
        st_d = st;
        case (st)
            A:       st_d = in ? B : A;
            B:       st_d = in ? B : C;
            C:       st_d = in ? D : A;
            D:       st_d = in ? B : C;
            default: st_d = A;
        endcase
    end

    assign hit = (st == D);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends an up-to-8-bit pattern MSB first,
// repeated up to 16 times, with a predicted 1-0-1 detector output.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
(
    input  logic              clk,
    input  logic              areset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [REP_W-1:0]  in_rep,
    input  logic              abort,
    output logic              out,
    output logic              busy,
    output logic              done,
    output logic              expect_hit
);

    tx_state_t         state, state_d;
    pattern_t          pat, pat_d;
    logic [LEN_W-1:0]  bit_idx, bit_idx_d;   // index of the bit currently on out
    logic [REP_W-1:0]  rep_cnt, rep_cnt_d;   // repetitions left after this one
    logic [LEN_W-1:0]  idx_dec;
    logic              out_d, done_d;
    logic              accept;

    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT);
    assign accept   = in_valid && in_ready && !abort;
    assign idx_dec  = bit_idx - 1'b1;

    // Control FSM register plus registered out/done
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= IDLE;
            pat     <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
            out     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            pat     <= pat_d;
            bit_idx <= bit_idx_d;
            rep_cnt <= rep_cnt_d;
            out     <= out_d;
            done    <= done_d;
        end
    end

    // Next-state and next-output: out_d is the bit shown in the following cycle
    always_comb begin
        state_d   = state;
        pat_d     = pat;
        bit_idx_d = bit_idx;
        rep_cnt_d = rep_cnt;
        out_d     = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    pat_d     = '{data: in_data, len: in_len};
                    bit_idx_d = in_len;
                    rep_cnt_d = in_rep;
                    out_d     = in_data[in_len];
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_idx == '0) begin
                    if (rep_cnt == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt - 1'b1;
                        bit_idx_d = pat.len;
                        out_d     = pat.data[pat.len];
                    end
                end else begin
                    bit_idx_d = idx_dec;
                    out_d     = pat.data[idx_dec];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Model watches the emitted stream every cycle, idle zeros included
    seq101_model u_model (
        .clk      (clk),
        .areset_n (areset_n),
        .in       (out),
        .hit      (expect_hit)
    );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       areset_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_data = '0;
    logic [2:0] in_len = '0;
    logic [3:0] in_rep = '0;
    logic       in_ready, out, busy, done, expect_hit;

    seq_pattern_tx dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_rep     (in_rep),
        .abort      (abort),
        .out        (out),
        .busy       (busy),
        .done       (done),
        .expect_hit (expect_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic out, busy, done, hit, ready;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   hit_log[$], done_log[$];

    // reference state: out/busy of current cycle, out history, bits still to send
    logic       m_out = 1'b0, m_busy = 1'b0;
    logic [2:0] m_hist = '0;
    logic       pend[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic act, logic expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, expv);
    endfunction

    function automatic void check_int(string nm, int act, int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, expv);
    endfunction

    function automatic void cmp_log(string nm, int got[$], int n, int a0 = 0, int a1 = 0, int a2 = 0);
        int w[3];
        w = '{a0, a1, a2};
        check_int({nm, "_cnt"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check_int($sformatf("%s_%0d", nm, i), got[i], w[i]);
    endfunction

    // monitor: compare every expectation due this cycle, log hit/done cycles
    always @(negedge clk) begin : mon
        exp_t e;
        if (expect_hit === 1'b1) hit_log.push_back(cyc);
        if (done === 1'b1) done_log.push_back(cyc);
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_chk++;
                $display("FAIL stale_exp cyc=%0d got=none exp_cyc=%0d", cyc, e.cyc);
            end else begin
                check("out", out, e.out);
                check("busy", busy, e.busy);
                check("done", done, e.done);
                check("expect_hit", expect_hit, e.hit);
                check("in_ready", in_ready, e.ready);
            end
        end
    end

    // drive one cycle of inputs and push what the outputs must be after the edge
    task automatic tick(input logic v, input logic [7:0] d, input logic [2:0] l,
                        input logic [3:0] r, input logic ab);
        exp_t       e;
        logic [2:0] h;
        logic       n_out, n_busy, n_done;
        in_valid = v; in_data = d; in_len = l; in_rep = r; abort = ab;
        h      = {m_hist[1:0], m_out};
        n_out  = 1'b0;
        n_busy = 1'b0;
        n_done = 1'b0;
        if (m_busy) begin
            if (ab) pend.delete();
            else if (pend.size() == 0) n_done = 1'b1;
            else begin
                n_out  = pend.pop_front();
                n_busy = 1'b1;
            end
        end else if (v && !ab) begin
            for (int k = 0; k <= int'(r); k++)
                for (int j = int'(l); j >= 0; j--)
                    pend.push_back(d[j]);
            n_out  = pend.pop_front();
            n_busy = 1'b1;
        end
        e.cyc = cyc + 1; e.out = n_out; e.busy = n_busy; e.done = n_done;
        e.hit = (h == 3'b101); e.ready = !n_busy;
        q.push_back(e);
        m_hist = h; m_out = n_out; m_busy = n_busy;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'hA5, 3'd7, 4'hF, 1'b0);
    endtask

    task automatic clr_logs();
        hit_log.delete();
        done_log.delete();
    endtask

    int t;

    initial begin
        #1 areset_n = 1'b0;
        #1;
        check("rst_out", out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hit", expect_hit, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #1 areset_n = 1'b1;
        idle(2);

        // single 101
        clr_logs(); t = cyc;
        tick(1'b1, 8'h05, 3'd2, 4'd0, 1'b0);
        idle(6);
        cmp_log("A_hit", hit_log, 1, t + 4);
        cmp_log("A_done", done_log, 1, t + 4);

        // 101 repeated three times
        clr_logs(); t = cyc;
        tick(1'b1, 8'h05, 3'd2, 4'd2, 1'b0);
        idle(12);
        cmp_log("B_hit", hit_log, 3, t + 4, t + 7, t + 10);
        cmp_log("B_done", done_log, 1, t + 10);

        // overlapping 10101
        clr_logs(); t = cyc;
        tick(1'b1, 8'h15, 3'd4, 4'd0, 1'b0);
        idle(6);
        cmp_log("C_hit", hit_log, 2, t + 4, t + 6);
        cmp_log("C_done", done_log, 1, t + 6);

        // in_valid held through a frame; next frame taken in the done cycle
        clr_logs(); t = cyc;
        tick(1'b1, 8'h05, 3'd2, 4'd0, 1'b0);
        repeat (4) tick(1'b1, 8'h06, 3'd2, 4'd0, 1'b0);
        idle(6);
        cmp_log("BP_done", done_log, 2, t + 4, t + 8);
        cmp_log("BP_hit", hit_log, 2, t + 4, t + 6);

        // abort beats in_valid in IDLE
        tick(1'b1, 8'hFF, 3'd7, 4'd0, 1'b1);
        idle(2);

        // abort during the 2nd bit of 0xFF
        clr_logs();
        tick(1'b1, 8'hFF, 3'd7, 4'd0, 1'b0);
        tick(1'b0, 8'h00, 3'd0, 4'd0, 1'b0);
        tick(1'b1, 8'h00, 3'd0, 4'd0, 1'b1);
        idle(4);
        cmp_log("AB_done", done_log, 0);

        // asynchronous reset mid-frame
        tick(1'b1, 8'hFF, 3'd7, 4'd1, 1'b0);
        idle(3);
        check("pre_rst_busy", busy, 1'b1);
        q.delete();
        #2 areset_n = 1'b0;
        #1;
        check("arst_out", out, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_hit", expect_hit, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        pend.delete();
        m_out = 1'b0; m_busy = 1'b0; m_hist = '0;
        @(posedge clk); @(posedge clk); #1 areset_n = 1'b1;
        idle(3);
        clr_logs(); t = cyc;
        tick(1'b1, 8'h05, 3'd2, 4'd0, 1'b0);
        idle(6);
        cmp_log("R_hit", hit_log, 1, t + 4);
        cmp_log("R_done", done_log, 1, t + 4);

        @(negedge clk); #1;
        check_int("q_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
